uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive front end for the on-chip UART. Sits between the `uart_rxd` pad and the Forth core's character-input port. Converts an asynchronous 8N1 stream into bytes delivered over a valid/ready handshake, and flags framing and overrun errors. In simulation it is exercised through the loopback of `uart_txd` to `uart_rxd`.

## Interface
- `CLKS_PER_BIT`, 139, clock cycles per bit (16 MHz / 115200); legal range 8..65535.
- `clk`  in  1  system clock (16 MHz).
- `rst`  in  1  reset, synchronous and active-high.
- `rxd`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  8  received byte; valid only while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: new byte completed while the previous byte was still unaccepted.

## Operation
- `rxd` passes through a 2-flop synchronizer. All logic uses the synchronized signal `rxs`.
- States and transitions:
  - IDLE: on `rxs` falling edge (previous 1, current 0), clear the bit counter and go to START.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division), then sample `rxs`. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE.
  - DATA: sample every `CLKS_PER_BIT` cycles, shifting in LSB first. After 8 samples go to PARITY (macro on) or STOP.
  - PARITY: sample once after `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - If 1: commit the byte (see below) and go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to BREAK_WAIT.
  - BREAK_WAIT: stay until `rxs`=1, then go to IDLE. Break conditions therefore yield exactly one `frame_err`.
- Commit with `rx_valid`=0: load `rx_data` and set `rx_valid`.
- Commit with `rx_valid`=1:
  - If `rx_ready`=1 in the same cycle: the old byte is accepted, the new byte loads, `rx_valid` stays 1, no overrun.
  - Otherwise: the new byte is dropped, `rx_data` keeps the old value, and `overrun` pulses.
- `rx_valid` clears on the cycle after `rx_valid & rx_ready`. `rx_ready` while `rx_valid`=0 is ignored.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. The counter reloads to 0 on every sample, so no drift accumulates from wrap.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0.
  - State IDLE, counters 0.
  - Both synchronizer flops =1 (idle line).
- Reset asserted mid-frame aborts the frame immediately; there is no output activity until the next falling edge after release.
- Latency: `rxd` falling edge to `rx_valid` rising is 3 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles (+`CLKS_PER_BIT` with parity). This includes 2 synchronizer cycles and 1 edge-detect cycle. The bench allows ±1.
- `frame_err` and `overrun` are asserted for exactly one cycle, aligned with the stop-bit sample cycle.
- Back-to-back frames: IDLE is re-entered in the stop-bit sample cycle. This allows the next start edge half a bit early and tolerates ±4% baud mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A 9th bit (even parity) is expected after the data bits.
  - On mismatch the byte is discarded and `frame_err` pulses. The FSM then goes to STOP-check as normal and does not enter BREAK_WAIT unless the stop bit is also 0.
- Undefined: no PARITY state; plain 8N1.

## Structure
- Package `uart_pkg`:
  - State encodings (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT; 3-bit).
  - `UART_DEFAULT_CLKS_PER_BIT`=139.
  - Shared with the future `uart_tx`.
- One sub-module: `sync_2ff` (parameterized reset value). It is reused for `gpio` inputs.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Send 0x55 at nominal baud with `rx_ready`=1 -> `rx_data`=0x55, one-cycle `rx_valid` at edge+3+8+144 (±1); no error pulses.
- Send 0xA3 then 0x0F back-to-back with `rx_ready`=0 until both frames end -> `rx_data`=0xA3 held, one `overrun` pulse at the 0x0F stop sample. Raising `rx_ready` clears `rx_valid` next cycle.
- 6-cycle low glitch on `rxd` -> no `rx_valid`, no `frame_err`, FSM back in IDLE.
- Frame 0xFF with stop bit forced 0, then line held low 40 bit-times -> exactly one `frame_err`, no `rx_valid`. Next valid 0x3C after line returns high is received correctly.
- Assert `rst` for 1 cycle at mid data bit 4 of 0x81 -> no `rx_valid` for that frame; all outputs 0. The following 0x7E is received.
- Baud skew: transmit 0xC9 at 15 and at 17 cycles/bit -> both are received as 0xC9. With `UART_RX_PARITY_EN`, a wrong parity bit -> `frame_err`, no `rx_valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } uart_state_t;

    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 139;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs, with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with valid/ready output, framing-error and overrun pulses.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bitn, bitn_nx;
    logic [7:0]       shreg, shreg_nx;
    logic             par_bad, par_bad_nx;
    logic             rxs, rxs_d;
    logic [1:0]       flush;
    logic             armed;
    logic             tick;
    logic             commit;
    logic             ferr_set;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    // The synchronizer resets to idle-high; hold off edge detection until it
    // carries real line values, so a line that is low at release is not a start.
    assign armed = (flush == 2'd3);
    assign tick  = (cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bitn    <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
            rxs_d   <= 1'b1;
            flush   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bitn    <= bitn_nx;
            shreg   <= shreg_nx;
            par_bad <= par_bad_nx;
            rxs_d   <= rxs;
            if (!armed)
                flush <= flush + 2'd1;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        bitn_nx    = bitn;
        shreg_nx   = shreg;
        par_bad_nx = par_bad;
        commit     = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (armed && rxs_d && !rxs) begin
                    state_nx   = ST_START;
                    bitn_nx    = '0;
                    par_bad_nx = 1'b0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    state_nx = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_nx   = '0;
                    shreg_nx = {rxs, shreg[7:1]};
                    bitn_nx  = bitn + 3'd1;
                    if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = ST_PARITY;
`else
                        state_nx = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    cnt_nx     = '0;
                    par_bad_nx = (rxs != even_parity(shreg));
                    state_nx   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    cnt_nx = '0;
                    if (rxs) begin
                        // Re-enter IDLE mid stop bit so an early next start edge is caught.
                        state_nx = ST_IDLE;
                        commit   = !par_bad;
                        ferr_set = par_bad;
                    end else begin
                        state_nx = ST_BREAK_WAIT;
                        ferr_set = 1'b1;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                cnt_nx = '0;
                if (rxs)
                    state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= 1'b0;
            if (commit) begin
                // A same-cycle accept frees the holding register for the new byte.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks/bit; honours UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 3 + C / 2 + 10 * C;
`else
    localparam int LAT = 3 + C / 2 + 9 * C;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Event log gathered by the monitor; the stimulus only reads it.
    int         rise_cnt = 0, vhigh_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, acc_cnt = 0;
    int         last_rise = 0, last_ovr = 0;
    logic [7:0] acc_mem [0:255];
    logic       valid_d = 1'b0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && !valid_d) begin
                rise_cnt++;
                last_rise = cyc;
            end
            if (rx_valid) vhigh_cnt++;
            if (rx_valid && rx_ready) begin
                acc_mem[acc_cnt[7:0]] = rx_data;
                acc_cnt++;
            end
            if (frame_err) ferr_cnt++;
            if (overrun) begin
                ovr_cnt++;
                last_ovr = cyc;
            end
        end
        valid_d = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; rst pulses for the single cycle at index rst_at (-1 for none).
    // The line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_v,
                              input logic par_flip, input int rst_at, output int fall);
        logic bits[$];
        int   k;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back((^b) ^ par_flip);
`endif
        bits.push_back(stop_v);
        fall = cyc;
        k = 0;
        for (int j = 0; j < bits.size(); j++) begin
            rxd = bits[j];
            for (int c = 0; c < cpb; c++) begin
                rst = (k == rst_at);
                tick(1);
                if (k == rst_at) begin
                    check("rst_mid_data", {24'd0, rx_data}, 32'h00);
                    check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
                    check("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
                    check("rst_mid_ovr", {31'd0, overrun}, 32'd0);
                end
                k++;
            end
        end
        rst = 1'b0;
    endtask

    function automatic int within1(input int obs, input int exp);
        return (obs >= exp - 1 && obs <= exp + 1) ? exp : obs;
    endfunction

    initial begin
        int         r0, f0, o0, v0, a0, fall, fall2;
        logic [7:0] b;
        logic [7:0] exp_q[$];

        rst = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b0;
        tick(5);
        check("reset_data", {24'd0, rx_data}, 32'h00);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Nominal 0x55, consumer always ready
        rx_ready = 1'b1;
        r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt; v0 = vhigh_cnt; a0 = acc_cnt;
        send_frame(8'h55, C, 1'b1, 1'b0, -1, fall);
        rxd = 1'b1;
        tick(2 * C);
        check("t55_rises", rise_cnt - r0, 1);
        check("t55_data", {24'd0, acc_mem[a0[7:0]]}, 32'h55);
        check("t55_latency", within1(last_rise - fall, LAT), LAT);
        check("t55_valid_cycles", vhigh_cnt - v0, 1);
        check("t55_ferr", ferr_cnt - f0, 0);
        check("t55_ovr", ovr_cnt - o0, 0);

        // Random bytes with random idle gaps (gap 0 means back-to-back)
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, C, 1'b1, 1'b0, -1, fall);
            rxd = 1'b1;
            tick($urandom_range(0, 3 * C));
        end
        tick(2 * C);
        check("rand_count", acc_cnt - a0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check("rand_byte", {24'd0, acc_mem[8'(a0 + i)]}, {24'd0, exp_q[i]});
        check("rand_ferr", ferr_cnt - f0, 0);
        check("rand_ovr", ovr_cnt - o0, 0);

        // Overrun: two frames with consumer stalled
        rx_ready = 1'b0;
        o0 = ovr_cnt; a0 = acc_cnt;
        send_frame(8'hA3, C, 1'b1, 1'b0, -1, fall);
        send_frame(8'h0F, C, 1'b1, 1'b0, -1, fall2);
        rxd = 1'b1;
        tick(C);
        check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        check("ovr_data_held", {24'd0, rx_data}, 32'hA3);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_timing", within1(last_ovr - fall2, LAT), LAT);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_valid_clear", {31'd0, rx_valid}, 32'd0);
        check("ovr_accepted", {24'd0, acc_mem[a0[7:0]]}, 32'hA3);
        check("ovr_accept_count", acc_cnt - a0, 1);

        // 6-cycle glitch must be rejected, then a normal frame still works
        r0 = rise_cnt; f0 = ferr_cnt;
        rxd = 1'b0;
        tick(6);
        rxd = 1'b1;
        tick(3 * C);
        check("glitch_rises", rise_cnt - r0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        a0 = acc_cnt;
        send_frame(8'h96, C, 1'b1, 1'b0, -1, fall);
        rxd = 1'b1;
        tick(2 * C);
        check("post_glitch_byte", {24'd0, acc_mem[a0[7:0]]}, 32'h96);

        // Bad stop bit followed by a long break
        r0 = rise_cnt; f0 = ferr_cnt;
        send_frame(8'hFF, C, 1'b0, 1'b0, -1, fall);
        tick(40 * C);
        rxd = 1'b1;
        tick(2 * C);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_rises", rise_cnt - r0, 0);
        a0 = acc_cnt;
        send_frame(8'h3C, C, 1'b1, 1'b0, -1, fall);
        rxd = 1'b1;
        tick(2 * C);
        check("post_break_count", acc_cnt - a0, 1);
        check("post_break_byte", {24'd0, acc_mem[a0[7:0]]}, 32'h3C);

        // Reset pulse in the middle of data bit 4
        r0 = rise_cnt; f0 = ferr_cnt;
        send_frame(8'h81, C, 1'b1, 1'b0, 5 * C + C / 2, fall);
        rxd = 1'b1;
        tick(3 * C);
        check("rst_frame_rises", rise_cnt - r0, 0);
        check("rst_frame_ferr", ferr_cnt - f0, 0);
        a0 = acc_cnt;
        send_frame(8'h7E, C, 1'b1, 1'b0, -1, fall);
        rxd = 1'b1;
        tick(2 * C);
        check("post_rst_byte", {24'd0, acc_mem[a0[7:0]]}, 32'h7E);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit: byte discarded with one framing error
        r0 = rise_cnt; f0 = ferr_cnt;
        send_frame(8'h5A, C, 1'b1, 1'b1, -1, fall);
        rxd = 1'b1;
        tick(2 * C);
        check("parity_ferr", ferr_cnt - f0, 1);
        check("parity_rises", rise_cnt - r0, 0);
`else
        // Transmitter baud skew of -1/+1 clock per bit
        a0 = acc_cnt; f0 = ferr_cnt;
        send_frame(8'hC9, 15, 1'b1, 1'b0, -1, fall);
        rxd = 1'b1;
        tick(2 * C);
        send_frame(8'hC9, 17, 1'b1, 1'b0, -1, fall);
        rxd = 1'b1;
        tick(2 * C);
        check("skew_count", acc_cnt - a0, 2);
        check("skew15_byte", {24'd0, acc_mem[a0[7:0]]}, 32'hC9);
        check("skew17_byte", {24'd0, acc_mem[8'(a0 + 1)]}, 32'hC9);
        check("skew_ferr", ferr_cnt - f0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
